// File: rtl/imm_encoder_pkg.sv
// Shared types and constants for the RV32 immediate encoder.
// Range limits back the optional IMM_ENC_RANGE_CHECK_EN checks.
package imm_encoder_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int IMM_IS_MIN = -2048;
    localparam int IMM_IS_MAX = 2047;
    localparam int IMM_B_MIN  = -4096;
    localparam int IMM_B_MAX  = 4094;
    localparam int IMM_J_MIN  = -1048576;
    localparam int IMM_J_MAX  = 1048574;

    typedef struct packed {
        logic [1:0]  src;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [20:0] imm;
        logic        range_err;
        logic        align_err;
    } s1_t;

    function automatic logic imm_out_of_range(input logic [1:0] src,
                                              input logic [31:0] imm);
        int s;
        int lo;
        int hi;
        s = $signed(imm);
        lo = IMM_IS_MIN;
        hi = IMM_IS_MAX;
        unique case (imm_src_e'(src))
            IMM_I, IMM_S: begin
                lo = IMM_IS_MIN;
                hi = IMM_IS_MAX;
            end
            IMM_B: begin
                lo = IMM_B_MIN;
                hi = IMM_B_MAX;
            end
            IMM_J: begin
                lo = IMM_J_MIN;
                hi = IMM_J_MAX;
            end
        endcase
        return (s < lo) || (s > hi);
    endfunction

endpackage

// File: rtl/imm_enc_pack.sv
// Combinational packer: format plus register fields and immediate
// bits to an RV32 instruction word.
module imm_enc_pack
    import imm_encoder_pkg::*;
(
    input  logic [1:0]  imm_src,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [20:0] imm,
    output logic [31:0] instr
);

    always_comb begin
        instr = '0;
        unique case (imm_src_e'(imm_src))
            IMM_I: instr = {imm[11:0], rs1, funct3, rd, opcode};
            IMM_S: instr = {imm[11:5], rs2, rs1, funct3,
                            imm[4:0], opcode};
            IMM_B: instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                            imm[4:1], imm[11], opcode};
            IMM_J: instr = {imm[20], imm[10:1], imm[11],
                            imm[19:12], rd, opcode};
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready RV32 immediate encoder (I/S/B/J).
// Define IMM_ENC_RANGE_CHECK_EN to flag bad immediates and emit NOPs.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       IMMSrc,
    input  logic [6:0]       OPCODE,
    input  logic [4:0]       RD,
    input  logic [4:0]       RS1,
    input  logic [4:0]       RS2,
    input  logic [2:0]       FUNCT3,
    input  logic [width-1:0] IMM,
    output logic [width-1:0] INSTR,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             RANGE_ERR,
    output logic             ALIGN_ERR,
    output logic [15:0]      ENC_COUNT
);

    logic        s1_valid_q, s1_valid_d;
    s1_t         s1_q, s1_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] instr_q, instr_d;
    logic        range_err_q, range_err_d;
    logic        align_err_q, align_err_d;
    logic [15:0] count_q, count_d;

    logic        s2_load;
    logic        in_fire;
    logic        out_fire;
    logic        range_chk;
    logic        align_chk;
    logic [31:0] packed_word;

    assign s2_load  = !s2_valid_q || OUT_READY;
    assign IN_READY = !RST && (!s1_valid_q || s2_load);
    assign in_fire  = IN_VALID && IN_READY;
    assign out_fire = s2_valid_q && OUT_READY;

`ifdef IMM_ENC_RANGE_CHECK_EN
    always_comb begin
        range_chk = imm_out_of_range(IMMSrc, IMM);
        align_chk = IMM[0] && ((IMMSrc == IMM_B) || (IMMSrc == IMM_J));
    end
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^IMM[31:21];
    assign range_chk = 1'b0;
    assign align_chk = 1'b0;
`endif

    imm_enc_pack u_pack (
        .imm_src (s1_q.src),
        .opcode  (s1_q.opcode),
        .rd      (s1_q.rd),
        .rs1     (s1_q.rs1),
        .rs2     (s1_q.rs2),
        .funct3  (s1_q.funct3),
        .imm     (s1_q.imm),
        .instr   (packed_word)
    );

    always_comb begin
        s1_d        = s1_q;
        s2_valid_d  = s2_valid_q;
        instr_d     = instr_q;
        range_err_d = range_err_q;
        align_err_d = align_err_q;
        count_d     = count_q;

        if (in_fire) begin
            s1_d.src       = IMMSrc;
            s1_d.opcode    = OPCODE;
            s1_d.rd        = RD;
            s1_d.rs1       = RS1;
            s1_d.rs2       = RS2;
            s1_d.funct3    = FUNCT3;
            s1_d.imm       = IMM[20:0];
            s1_d.range_err = range_chk;
            s1_d.align_err = align_chk;
        end
        s1_valid_d = in_fire || (s1_valid_q && !s2_load);

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                instr_d     = packed_word;
                range_err_d = s1_q.range_err;
                align_err_d = s1_q.align_err;
`ifdef IMM_ENC_RANGE_CHECK_EN
                // Bad immediates still flow through, but as a harmless NOP
                if (s1_q.range_err || s1_q.align_err) begin
                    instr_d = NOP_INSTR;
                end
`endif
            end
        end

        if (out_fire) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            s2_valid_q  <= 1'b0;
            instr_q     <= '0;
            range_err_q <= 1'b0;
            align_err_q <= 1'b0;
            count_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            s2_valid_q  <= s2_valid_d;
            instr_q     <= instr_d;
            range_err_q <= range_err_d;
            align_err_q <= align_err_d;
            count_q     <= count_d;
        end
    end

    assign INSTR     = instr_q;
    assign OUT_VALID = s2_valid_q;
    assign RANGE_ERR = range_err_q;
    assign ALIGN_ERR = align_err_q;
    assign ENC_COUNT = count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vectors, backpressure,
// mid-stream reset and random traffic against a queue reference model.
module tb_imm_encoder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [1:0]  IMMSrc = '0;
    logic [6:0]  OPCODE = '0;
    logic [4:0]  RD = '0;
    logic [4:0]  RS1 = '0;
    logic [4:0]  RS2 = '0;
    logic [2:0]  FUNCT3 = '0;
    logic [31:0] IMM = '0;
    logic [31:0] INSTR;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic        RANGE_ERR;
    logic        ALIGN_ERR;
    logic [15:0] ENC_COUNT;

    always #5 CLK = ~CLK;

    imm_encoder #(.width(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IMMSrc    (IMMSrc),
        .OPCODE    (OPCODE),
        .RD        (RD),
        .RS1       (RS1),
        .RS2       (RS2),
        .FUNCT3    (FUNCT3),
        .IMM       (IMM),
        .INSTR     (INSTR),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .RANGE_ERR (RANGE_ERR),
        .ALIGN_ERR (ALIGN_ERR),
        .ENC_COUNT (ENC_COUNT)
    );

    typedef struct {
        logic [31:0] instr;
        logic        rerr;
        logic        aerr;
        int          stamp;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   cnt = 0;
    int   bnd[12] = '{-2048, 2047, 2048, -2049, -4096, 4094,
                      4095, -4098, -1048576, 1048574, 1048576, -1048578};

    function automatic logic [31:0] ref_word(input logic [1:0] src,
        input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] i);
        logic [31:0] o, d, a, b, f, base;
        o = 32'(op);
        d = 32'(rd);
        a = 32'(rs1);
        b = 32'(rs2);
        f = 32'(f3);
        base = o | (f << 12) | (a << 15);
        case (src)
            2'd0: return base | (d << 7) | ((i & 32'hfff) << 20);
            2'd1: return base | (b << 20) | (((i >> 5) & 32'h7f) << 25)
                         | ((i & 32'h1f) << 7);
            2'd2: return base | (b << 20) | (((i >> 12) & 32'h1) << 31)
                         | (((i >> 5) & 32'h3f) << 25)
                         | (((i >> 1) & 32'hf) << 8)
                         | (((i >> 11) & 32'h1) << 7);
            default: return o | (d << 7) | (((i >> 12) & 32'hff) << 12)
                         | (((i >> 11) & 32'h1) << 20)
                         | (((i >> 1) & 32'h3ff) << 21)
                         | (((i >> 20) & 32'h1) << 31);
        endcase
    endfunction

    function automatic bit ref_range(input logic [1:0] src,
                                     input logic [31:0] i);
        int s;
        s = $signed(i);
        case (src)
            2'd0, 2'd1: return (s < -2048) || (s > 2047);
            2'd2:       return (s < -4096) || (s > 4094);
            default:    return (s < -1048576) || (s > 1048574);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at posedge+1, check and update model at negedge
    task automatic step(input bit v, input logic [1:0] src,
        input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] im,
        input bit ordy, input bit ugold, input logic [31:0] gold,
        output bit acc);
        bit          exp_rdy, exp_ov, re, ae;
        logic [31:0] w;
        RST = 1'b0;
        IN_VALID = v;
        IMMSrc = src;
        OPCODE = op;
        RD = rd;
        RS1 = rs1;
        RS2 = rs2;
        FUNCT3 = f3;
        IMM = im;
        OUT_READY = ordy;
        @(negedge CLK);
        exp_rdy = (q.size() < 2) || ordy;
        exp_ov = (q.size() > 0) && (q[0].stamp < cyc);
        chk("in_ready", 32'(IN_READY), 32'(exp_rdy));
        chk("out_valid", 32'(OUT_VALID), 32'(exp_ov));
        if (exp_ov) begin
            chk("instr", INSTR, q[0].instr);
            chk("range_err", 32'(RANGE_ERR), 32'(q[0].rerr));
            chk("align_err", 32'(ALIGN_ERR), 32'(q[0].aerr));
        end
        chk("enc_count", 32'(ENC_COUNT), 32'(cnt & 16'hffff));
        acc = v && exp_rdy;
        if (exp_ov && ordy) begin
            q.delete(0);
            cnt++;
        end
        if (acc) begin
            re = ref_range(src, im);
            ae = (src >= 2'd2) && im[0];
            w = ref_word(src, op, rd, rs1, rs2, f3, im);
`ifdef IMM_ENC_RANGE_CHECK_EN
            if (re || ae) w = 32'h0000_0013;
`else
            re = 1'b0;
            ae = 1'b0;
`endif
            if (ugold) w = gold;
            q.push_back('{w, re, ae, cyc + 1});
        end
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, acc);
    endtask

    task automatic rst_step();
        RST = 1'b1;
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        @(negedge CLK);
        chk("in_ready_rst", 32'(IN_READY), 32'd0);
        @(posedge CLK);
        cyc++;
        #1;
        RST = 1'b0;
        q.delete();
        cnt = 0;
    endtask

    task automatic post_reset_check();
        @(negedge CLK);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_instr", INSTR, 32'd0);
        chk("rst_range_err", 32'(RANGE_ERR), 32'd0);
        chk("rst_align_err", 32'(ALIGN_ERR), 32'd0);
        chk("rst_enc_count", 32'(ENC_COUNT), 32'd0);
        chk("rst_in_ready", 32'(IN_READY), 32'd1);
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic rand_step(input bit v, input bit ordy, output bit acc);
        logic [31:0] im;
        case ($urandom_range(0, 3))
            0: im = 32'($urandom_range(0, 10000)) - 32'd5000;
            1: im = bnd[$urandom_range(0, 11)];
            2: im = $urandom;
            default: im = 32'($urandom_range(0, 2097151)) - 32'd1048576;
        endcase
        step(v, 2'($urandom_range(0, 3)), 7'($urandom), 5'($urandom),
             5'($urandom), 5'($urandom), 3'($urandom), im, ordy,
             1'b0, 32'd0, acc);
    endtask

    initial begin
        bit          acc;
        int          k;
        logic [31:0] g;
        @(posedge CLK);
        #1;
        rst_step();
        rst_step();
        post_reset_check();

        step(1, 2'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, -32'sd1,
             1, 1, 32'hFFF0_0093, acc);
        idle(3);
        step(1, 2'd1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 32'd8,
             1, 1, 32'h0020_A423, acc);
        step(1, 2'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4,
             1, 1, 32'hFE00_0EE3, acc);
        step(1, 2'd3, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048,
             1, 1, 32'h0010_00EF, acc);
`ifdef IMM_ENC_RANGE_CHECK_EN
        g = 32'h0000_0013;
`else
        g = 32'h8000_0093;
`endif
        step(1, 2'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048,
             1, 1, g, acc);
        step(1, 2'd2, 7'b1100011, 5'd0, 5'd3, 5'd4, 3'd1, 32'd3,
             1, 0, 32'd0, acc);
        idle(3);

        rst_step();
        post_reset_check();
        k = 0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] im;
            logic [4:0]  rd;
            im = 32'($urandom_range(0, 4000)) - 32'd2000;
            rd = 5'(i + 3);
            acc = 0;
            while (!acc && k < 30) begin
                step(1, 2'd0, 7'b0010011, rd, 5'd7, 5'd0, 3'd0, im,
                     k >= 3, 0, 32'd0, acc);
                k++;
            end
            if (!acc) chk("bp_accept_timeout", 32'(i), 32'd99);
        end
        idle(4);
        chk("bp_enc_count", 32'(ENC_COUNT), 32'd4);

        step(1, 2'd1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 32'd100,
             0, 0, 32'd0, acc);
        step(1, 2'd3, 7'b1101111, 5'd5, 5'd0, 5'd0, 3'd0, 32'd4096,
             0, 0, 32'd0, acc);
        rst_step();
        post_reset_check();
        step(1, 2'd2, 7'b1100011, 5'd0, 5'd9, 5'd10, 3'd5, 32'd64,
             1, 0, 32'd0, acc);
        idle(3);

        for (int n = 0; n < 400; n++) begin
            rand_step(1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 2) != 0), acc);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
